// File: rtl/in_shift_reg_pkg.sv
// Shared definitions for the serial-to-parallel receiver and its matching
// word-serializing transmitter: default frame geometry, FSM state type and
// the counter width helper.
package in_shift_reg_pkg;

    // Default frame geometry, shared with the transmitter.
    localparam int IN_SHIFT_REG_N1 = 76;
    localparam int IN_SHIFT_REG_N2 = 7;

    typedef enum logic {
        SHIFT  = 1'b0,
        UNLOAD = 1'b1
    } state_e;

    // Counter width for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/in_shift_lane.sv
// One N1-bit lane register. Shifts a serial bit in at the LSB end (MSB of the
// word arrives first) or loads a whole word from the next lane during unload.
// The two enables are mutually exclusive by construction in the top.
module in_shift_lane
    import in_shift_reg_pkg::*;
#(
    parameter int N1 = IN_SHIFT_REG_N1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          shift_en,
    input  logic          load_en,
    input  logic          serial_in,
    input  logic [N1-1:0] load_data,
    output logic [N1-1:0] data_q
);

    logic [N1-1:0] data_d;

    // Next lane contents: shift-in, parallel load, or hold.
    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {data_q[N1-2:0], serial_in};
        end else if (load_en) begin
            data_d = load_data;
        end
    end

    // Lane storage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/in_shift_reg.sv
// Multi-lane serial-to-parallel receiver. Captures N2 lanes of N1 bits each,
// MSB first, then hands the words out one per OutValid/OutReady handshake in
// lane order 0..N2-1 by shifting the lane registers down toward lane 0.
// Optional feature macro: IN_SHIFT_REG_OVERRUN_EN adds a sticky Overrun flag
// that records bit strobes dropped while unloading.
//
// state  | meaning
// SHIFT  | accepting bit strobes, BitCnt counts bits of the current frame
// UNLOAD | frame complete, OutValid high, WordCnt counts delivered words
module in_shift_reg
    import in_shift_reg_pkg::*;
#(
    parameter int N1 = IN_SHIFT_REG_N1,
    parameter int N2 = IN_SHIFT_REG_N2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          InValid,
    input  logic [N2-1:0] In,
    input  logic          OutReady,
    output logic          OutValid,
    output logic [N1-1:0] OutData,
    output logic          Busy
`ifdef IN_SHIFT_REG_OVERRUN_EN
    ,
    output logic          Overrun
`endif
);

    localparam int BW = cnt_width(N1);
    localparam int WW = cnt_width(N2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N1 - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(N2 - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          xfer;
    logic [N1-1:0] lane_q [N2];

    // Clear wins over both a strobe and a transfer in the same cycle.
    assign accept = (state_q == SHIFT) && InValid && !Clear;
    assign xfer   = out_valid_q && OutReady && !Clear;

    // Lane array: lane x shifts in In[x]; on a transfer each lane takes the
    // next one's word and the last lane is refilled with zeros.
    for (genvar x = 0; x < N2; x++) begin : g_lane
        logic [N1-1:0] next_word;
        if (x == N2 - 1) begin : g_last
            assign next_word = '0;
        end else begin : g_mid
            assign next_word = lane_q[x+1];
        end

        in_shift_lane #(
            .N1 (N1)
        ) u_lane (
            .Clock     (Clock),
            .Reset     (Reset),
            .shift_en  (accept),
            .load_en   (xfer),
            .serial_in (In[x]),
            .load_data (next_word),
            .data_q    (lane_q[x])
        );
    end

    assign OutData  = lane_q[0];
    assign OutValid = out_valid_q;
    assign Busy     = busy_q;

    // Next state and counters; outputs are derived from the next state so
    // they come straight from flops.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (Clear) begin
            state_d    = SHIFT;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (accept) begin
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                state_d   = UNLOAD;
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end else if (xfer) begin
            if (word_cnt_q == WORD_LAST) begin
                word_cnt_d = '0;
                state_d    = SHIFT;
            end else begin
                word_cnt_d = word_cnt_q + WW'(1);
            end
        end
        out_valid_d = (state_d == UNLOAD);
        busy_d      = (state_d == UNLOAD);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= SHIFT;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IN_SHIFT_REG_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky record of strobes that arrived while unloading.
    always_comb begin
        overrun_d = overrun_q;
        if (Clear) begin
            overrun_d = 1'b0;
        end else if ((state_q == UNLOAD) && InValid) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag storage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign Overrun = overrun_q;
`endif

endmodule
